uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes from the core enter a DEPTH-entry FIFO through a valid/ready port.
// A bit-timing FSM pops them and shifts them out LSB-first on ser_tx.
module uart_tx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     ser_tx
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic          w_push;
    logic          w_pop;
    logic          w_baud_tc;
    logic          w_nonempty;

    // Ready comes from the registered count only, so a same-cycle pop never
    // frees a slot for a write while full.
    assign w_nonempty = (r_count != '0);
    assign wr_ready   = (r_count != CNT_FULL);
    assign w_push     = wr_valid && wr_ready;
    assign w_baud_tc  = (r_baud == BAUD_LAST);
    // Pop only when a new frame starts: out of IDLE, or straight from STOP.
    assign w_pop      = w_nonempty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_tc));

    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || w_nonempty;
    assign ser_tx     = r_tx;

    // FIFO storage: written at the tail on an accepted byte, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bit-timing FSM: start bit, 8 data bits LSB-first, stop bit, DIV clocks each.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_tc) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_tc) begin
                        r_baud    <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_tc) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            // Back-to-back: next start bit follows the stop bit directly.
                            r_shift <= r_mem[r_rptr];
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
